// File: rtl/retry_pkg.sv
// Shared types and default sizing for the retry-source stage.
//   id_t         : transfer ID as carried on id_o / retry_id_i / release_id_i.
//   retry_cnt_t  : per-ID re-issue counter, wide enough to hold DefMaxRetries.
//   entry_t      : one ID-table entry {busy, retry_cnt}.
// The Def* localparams are the default sizes used by the interface and the
// top-level module parameters.
package retry_pkg;

    localparam int unsigned DefDataWidth      = 16;
    localparam int unsigned DefIDSize         = 4;
    localparam int unsigned DefMaxRetries     = 3;
    localparam int unsigned DefRetryFifoDepth = 4;

    typedef logic [DefIDSize-1:0]                  id_t;
    typedef logic [$clog2(DefMaxRetries+1)-1:0]    retry_cnt_t;

    typedef struct packed {
        logic       busy;
        retry_cnt_t retry_cnt;
    } entry_t;

endpackage

// File: rtl/retry_start_bounded_if.sv
// Handshake bundle of the retry-source stage.
//   upstream   : data_i, valid_i, ready_o
//   downstream : data_o, id_o, valid_o, ready_i
//   retry      : retry_id_i, retry_valid_i, retry_ready_o
//   release    : release_id_i, release_valid_i (no ready, always accepted)
//   status     : fail_id_o, fail_valid_o, inflight_o
// Modport slave is the stage itself; master is whoever drives it.
interface retry_start_bounded_if
    import retry_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned IDSize    = DefIDSize
);

    logic [DataWidth-1:0] data_i;
    logic                 valid_i;
    logic                 ready_o;

    logic [DataWidth-1:0] data_o;
    logic [IDSize-1:0]    id_o;
    logic                 valid_o;
    logic                 ready_i;

    logic [IDSize-1:0]    retry_id_i;
    logic                 retry_valid_i;
    logic                 retry_ready_o;

    logic [IDSize-1:0]    release_id_i;
    logic                 release_valid_i;

    logic [IDSize-1:0]    fail_id_o;
    logic                 fail_valid_o;
    logic [IDSize:0]      inflight_o;

    modport slave (
        input  data_i, valid_i, ready_i,
        input  retry_id_i, retry_valid_i,
        input  release_id_i, release_valid_i,
        output ready_o, data_o, id_o, valid_o,
        output retry_ready_o, fail_id_o, fail_valid_o, inflight_o
    );

    modport master (
        output data_i, valid_i, ready_i,
        output retry_id_i, retry_valid_i,
        output release_id_i, release_valid_i,
        input  ready_o, data_o, id_o, valid_o,
        input  retry_ready_o, fail_id_o, fail_valid_o, inflight_o
    );

endinterface

// File: rtl/fifo_v3.sv
// Common synchronous FIFO (show-ahead: data_o is the head while !empty_o).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : synchronous clear of all entries
//   full_o/empty_o: occupancy flags
//   data_i/push_i : write port; a push while full is accepted only together
//                   with a pop in the same cycle
//   data_o/pop_i  : read port; pop on empty is ignored
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AddrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == AddrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/retry_start_bounded.sv
// Retry-source stage for time-redundant pipelines.
// Each accepted upstream transfer gets the next ID in strict order and its
// payload is held in an ID-indexed table until released. Retry requests are
// queued in a small FIFO and re-issue the stored payload under the same ID,
// up to MaxRetries times; one more retry frees the entry and pulses fail_*.
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : retry_start_bounded_if.slave (upstream, downstream, retry,
//           release and status signals)
module retry_start_bounded
    import retry_pkg::*;
#(
    parameter int unsigned DataWidth      = DefDataWidth,
    parameter int unsigned IDSize         = DefIDSize,
    parameter int unsigned MaxRetries     = DefMaxRetries,
    parameter int unsigned RetryFifoDepth = DefRetryFifoDepth
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    retry_start_bounded_if.slave  bus
);

    localparam int unsigned Entries = 2 ** IDSize;
    localparam int unsigned CntW    = $clog2(MaxRetries + 1);
    localparam int unsigned InfW    = IDSize + 1;

    typedef logic [IDSize-1:0]    id_lt;
    typedef logic [CntW-1:0]      cnt_lt;
    typedef logic [DataWidth-1:0] data_lt;

    // ID table
    logic [Entries-1:0] busy_q, busy_d;
    cnt_lt              cnt_q [Entries];
    cnt_lt              cnt_d [Entries];
    data_lt             tbl_q [Entries];
    id_lt               next_id_q, next_id_d;
    logic [InfW-1:0]    inflight_q, inflight_d;

    // Output stage and failure pulse
    logic   out_valid_q, out_valid_d;
    data_lt out_data_q, out_data_d;
    id_lt   out_id_q, out_id_d;
    logic   fail_valid_q;
    id_lt   fail_id_q;

    // Retry FIFO
    logic fifo_full, fifo_empty;
    id_lt head_id;
    logic rst_n;

    logic stage_can_load, pop, push, alloc;
    logic rel_hit, head_live, head_exhausted, reissue, fail;

    assign rst_n = ~rst_i;

    fifo_v3 #(
        .DATA_WIDTH (IDSize),
        .DEPTH      (RetryFifoDepth)
    ) i_retry_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_n),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (bus.retry_id_i),
        .push_i  (push),
        .data_o  (head_id),
        .pop_i   (pop)
    );

    assign stage_can_load = !out_valid_q || bus.ready_i;

    // Retries own the output stage whenever one is pending.
    assign pop = !rst_i && stage_can_load && !fifo_empty;

    // A release in the same cycle as a pop of that ID makes the pop stale.
    assign rel_hit   = bus.release_valid_i && busy_q[bus.release_id_i];
    assign head_live = busy_q[head_id] &&
                       !(rel_hit && (bus.release_id_i == head_id));

    assign head_exhausted = (cnt_q[head_id] >= cnt_lt'(MaxRetries));
    assign reissue        = pop && head_live && !head_exhausted;
    assign fail           = pop && head_live && head_exhausted;

    assign bus.ready_o = !rst_i && stage_can_load && fifo_empty && !busy_q[next_id_q];
    assign alloc       = bus.valid_i && bus.ready_o;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign bus.retry_ready_o = !rst_i && (!fifo_full || pop);
    assign push              = bus.retry_valid_i && bus.retry_ready_o;

    always_comb begin
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        next_id_d  = next_id_q;
        inflight_d = inflight_q;

        if (rel_hit) begin
            busy_d[bus.release_id_i] = 1'b0;
            cnt_d[bus.release_id_i]  = '0;
        end
        if (fail) begin
            busy_d[head_id] = 1'b0;
            cnt_d[head_id]  = '0;
        end
        if (reissue) begin
            cnt_d[head_id] = cnt_q[head_id] + 1'b1;
        end
        // alloc needs an empty FIFO, so it never coincides with a pop.
        if (alloc) begin
            busy_d[next_id_q] = 1'b1;
            cnt_d[next_id_q]  = '0;
            next_id_d         = next_id_q + 1'b1;
        end

        inflight_d = inflight_q + InfW'(alloc) - InfW'(rel_hit) - InfW'(fail);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (alloc) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.data_i;
            out_id_d    = next_id_q;
        end else if (reissue) begin
            out_valid_d = 1'b1;
            out_data_d  = tbl_q[head_id];
            out_id_d    = head_id;
        end else if (stage_can_load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q       <= '0;
            cnt_q        <= '{default: '0};
            next_id_q    <= '0;
            inflight_q   <= '0;
            out_valid_q  <= 1'b0;
            fail_valid_q <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            next_id_q    <= next_id_d;
            inflight_q   <= inflight_d;
            out_valid_q  <= out_valid_d;
            fail_valid_q <= fail;
        end
    end

    // Payload storage needs no reset: it is only read for busy entries.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            tbl_q[next_id_q] <= bus.data_i;
        end
        out_data_q <= out_data_d;
        out_id_q   <= out_id_d;
        fail_id_q  <= head_id;
    end

    assign bus.data_o       = out_data_q;
    assign bus.id_o         = out_id_q;
    assign bus.valid_o      = out_valid_q;
    assign bus.fail_valid_o = fail_valid_q;
    assign bus.fail_id_o    = fail_id_q;
    assign bus.inflight_o   = inflight_q;

endmodule
